// File: rtl/puf_eval_ctrl.sv
// RO-PUF evaluation sequencer: per bit clears the RO counters, runs both banks for a window,
// drains the synchronisers and compares the counts. Optional macro: PUF_TIE_FLAG_EN.
module puf_eval_ctrl #(
   parameter int NBITS = 8,
   parameter int WIN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic [7:0]       cnt_a,
   input  logic [7:0]       cnt_b,
   output logic             ro_en,
   output logic             cnt_clr,
   output logic [2:0]       sel,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] response,
   output logic [NBITS-1:0] tie_mask,
   output logic [2:0]       state_dbg
);

   // Handshake: start is a single-cycle request honoured only in IDLE; done is a
   // single-cycle pulse with response/tie_mask valid, which then hold until the next start.

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_RUN     = 3'd2,
      S_SETTLE  = 3'd3,
      S_COMPARE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [2:0]       LAST_IDX = 3'(NBITS - 1);
   localparam logic [WIN_W-1:0] ONE_W    = {{(WIN_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [2:0]       idx_q;
   logic [WIN_W-1:0] timer_q;
   logic [WIN_W-1:0] win_q;
   logic [NBITS-1:0] resp_q;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ro_en   = 1'b0;
      cnt_clr = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      sel     = idx_q;
      case (state_q)
         S_IDLE: begin
            sel = 3'd0;
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_clr = 1'b1;
            busy    = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            ro_en = 1'b1;
            busy  = 1'b1;
            if (timer_q == win_q - ONE_W) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (timer_q == ONE_W) state_d = S_COMPARE;
         end
         S_COMPARE: begin
            busy    = 1'b1;
            state_d = (idx_q == LAST_IDX) ? S_DONE : S_CLEAR;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // timer restarts from 0 on every state change, so it counts cycles spent in the current state
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         idx_q   <= 3'd0;
         timer_q <= '0;
         win_q   <= ONE_W;
         resp_q  <= '0;
      end else begin
         timer_q <= (state_d != state_q) ? '0 : timer_q + ONE_W;
         if (state_q == S_IDLE && start) begin
            win_q  <= (win_len == '0) ? ONE_W : win_len;
            idx_q  <= 3'd0;
            resp_q <= '0;
         end
         if (state_q == S_COMPARE) begin
            resp_q[idx_q] <= (cnt_a > cnt_b);
            if (state_d == S_CLEAR) idx_q <= idx_q + 3'd1;
         end
      end
   end

`ifdef PUF_TIE_FLAG_EN
   logic [NBITS-1:0] tie_q;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         tie_q <= '0;
      end else begin
         if (state_q == S_IDLE && start) tie_q <= '0;
         if (state_q == S_COMPARE) tie_q[idx_q] <= (cnt_a == cnt_b);
      end
   end

   assign tie_mask = tie_q;
`else
   assign tie_mask = '0;
`endif

   assign response  = resp_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: directed count patterns per RO index,
// expected response/tie/latency queued at start and checked by a done monitor.
module tb_puf_eval_ctrl;

   localparam int NBITS = 8;
   localparam int WIN_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [WIN_W-1:0] win_len = '0;
   logic [7:0]       cnt_a, cnt_b;
   logic             ro_en, cnt_clr, busy, done;
   logic [2:0]       sel, state_dbg;
   logic [NBITS-1:0] response, tie_mask;

   logic [7:0] a_tab [NBITS];
   logic [7:0] b_tab [NBITS];

   logic [NBITS-1:0] exp_resp_q[$];
   logic [NBITS-1:0] exp_tie_q[$];
   logic [31:0]      exp_cyc_q[$];
   logic [31:0]      exp_ro_q[$];
   logic [2:0]       exp_sel_q[$];

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int ro_cnt  = 0;

   puf_eval_ctrl #(.NBITS(NBITS), .WIN_W(WIN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .ro_en(ro_en), .cnt_clr(cnt_clr),
      .sel(sel), .busy(busy), .done(done), .response(response),
      .tie_mask(tie_mask), .state_dbg(state_dbg)
   );

   // clock / reset-independent cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // counter model: each bank reports the count programmed for the selected RO pair
   always_comb begin
      cnt_a = a_tab[sel];
      cnt_b = b_tab[sel];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [NBITS-1:0] tie_exp(input logic [NBITS-1:0] t);
`ifdef PUF_TIE_FLAG_EN
      return t;
`else
      return '0;
`endif
   endfunction

   task automatic set_tab(input logic [7:0] a_even, input logic [7:0] b_even,
                          input logic [7:0] a_odd, input logic [7:0] b_odd);
      for (int i = 0; i < NBITS; i++) begin
         a_tab[i] = (i % 2 == 0) ? a_even : a_odd;
         b_tab[i] = (i % 2 == 0) ? b_even : b_odd;
      end
   endtask

   task automatic flush_q();
      exp_resp_q.delete(); exp_tie_q.delete(); exp_cyc_q.delete();
      exp_ro_q.delete();   exp_sel_q.delete();
   endtask

   task automatic drive_start(input int w, input logic [NBITS-1:0] resp, input logic [NBITS-1:0] tie);
      int weff;
      weff = (w == 0) ? 1 : w;
      @(negedge clk);
      win_len = WIN_W'(w);
      start   = 1'b1;
      exp_resp_q.push_back(resp);
      exp_tie_q.push_back(tie_exp(tie));
      exp_cyc_q.push_back(32'(cyc + 1 + NBITS * (weff + 4)));
      exp_ro_q.push_back(32'(NBITS * weff));
      for (int i = 0; i < NBITS; i++) exp_sel_q.push_back(3'(i));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (exp_resp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_resp_q.size() != 0) begin
         check("done_timeout", 32'd0, 32'd1);
         flush_q();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   // monitor: checks CLEAR select order, RO-enable cycles, and every done against the queue
   always @(negedge clk) begin
      if (rst_n) begin
         ro_cnt = 0;
      end else begin
         if (ro_en) ro_cnt++;
         if (cnt_clr) begin
            if (exp_sel_q.size() == 0) check("unexpected_clear", 32'd1, 32'd0);
            else check("clear_sel", 32'(sel), 32'(exp_sel_q.pop_front()));
         end
         if (done) begin
            if (exp_resp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               check("response", 32'(response), 32'(exp_resp_q.pop_front()));
               check("tie_mask", 32'(tie_mask), 32'(exp_tie_q.pop_front()));
               check("latency", 32'(cyc), exp_cyc_q.pop_front());
               check("ro_en_cycles", 32'(ro_cnt), exp_ro_q.pop_front());
               check("busy_at_done", 32'(busy), 32'd0);
            end
            ro_cnt = 0;
         end
      end
   end

   initial begin
      int n;
      set_tab(8'd0, 8'd0, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      check("reset_outputs", {ro_en, cnt_clr, sel, busy, done, response, tie_mask},
            32'd0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // all pairs a>b, window 10
      set_tab(8'd50, 8'd40, 8'd50, 8'd40);
      drive_start(10, 8'hFF, 8'h00);
      repeat (3) @(negedge clk);
      check("busy_mid_eval", 32'(busy), 32'd1);
      wait_idle(300);

      // only odd indices win
      set_tab(8'd20, 8'd60, 8'd100, 8'd60);
      drive_start(4, 8'hAA, 8'h00);
      wait_idle(300);

      // zero window behaves as one cycle
      set_tab(8'd200, 8'd199, 8'd1, 8'd2);
      drive_start(0, 8'h55, 8'h00);
      wait_idle(300);

      // saturated equal counts
      set_tab(8'd255, 8'd255, 8'd255, 8'd255);
      drive_start(2, 8'h00, 8'hFF);
      wait_idle(300);

      // maximum window
      set_tab(8'd255, 8'd0, 8'd255, 8'd0);
      drive_start(255, 8'hFF, 8'h00);
      wait_idle(3000);

      // abort in the third RUN cycle of bit 2
      set_tab(8'd20, 8'd60, 8'd100, 8'd60);
      drive_start(10, 8'hAA, 8'h00);
      n = 0;
      while (!(sel == 3'd2 && ro_en) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reached_bit2_run", 32'(n < 200), 32'd1);
      repeat (2) @(negedge clk);
      check("ro_en_before_reset", 32'(ro_en), 32'd1);
      #1 rst_n = 1'b1;
      #1;
      check("ro_en_async_drop", 32'(ro_en), 32'd0);
      check("outputs_in_reset", {ro_en, cnt_clr, sel, busy, done, response, tie_mask},
            32'd0);
      flush_q();
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (20) @(negedge clk);
      drive_start(3, 8'hAA, 8'h00);
      wait_idle(300);

      // start re-pulsed and win_len changed while busy
      for (int i = 0; i < NBITS; i++) begin
         a_tab[i] = (i >= 2 && i <= 5) ? 8'd9 : 8'd3;
         b_tab[i] = 8'd5;
      end
      drive_start(5, 8'h3C, 8'h00);
      repeat (20) @(negedge clk);
      start   = 1'b1;
      win_len = 8'd200;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      win_len = 8'd1;
      wait_idle(300);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 8: response bits per evaluation, which is also the number of RO-pair selections (2..8).
REQ-002 SHALL have parameter WIN_W, default 8: width of the measurement window length input.
REQ-003 SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an evaluation; ignored unless idle.
REQ-006 SHALL have port win_len  input  WIN_W  oscillation window in clk cycles; sampled at start.
REQ-007 SHALL have port cnt_a  input  8  count of the first RO-bank counter, already synchronised to clk.
REQ-008 SHALL have port cnt_b  input  8  count of the second RO-bank counter, already synchronised to clk.
REQ-009 SHALL have port ro_en  output  1  enable to both RO banks.
REQ-010 SHALL have port cnt_clr  output  1  synchronous clear to both counters.
REQ-011 SHALL have port sel  output  3  RO select index driven to both bank muxes.
REQ-012 SHALL have port busy  output  1  high from the cycle after start until the DONE state is entered.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the response is valid.
REQ-014 SHALL have port response  output  NBITS  PUF response; holds its value until the next start.
REQ-015 SHALL have port tie_mask  output  NBITS  per-bit equal-count flags (see Configuration).

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, RUN, SETTLE, COMPARE and DONE.
REQ-017 SHALL, in IDLE with start=1, latch win_len (a value of 0 is treated as 1), set idx=0, clear response and tie_mask, and go to CLEAR.
REQ-018 SHALL, in CLEAR: drive cnt_clr=1, ro_en=0 and sel=idx for 1 cycle, then go to RUN.
REQ-019 SHALL, in RUN: drive ro_en=1 and sel=idx for exactly the latched win_len cycles, then go to SETTLE.
REQ-020 SHALL, in SETTLE: drive ro_en=0 for exactly 2 cycles (counter synchroniser drain), then go to COMPARE.
REQ-021 SHALL, in COMPARE (1 cycle): write response[idx] = (cnt_a > cnt_b), an unsigned 8-bit compare.
REQ-022 SHALL, on leaving COMPARE: go to DONE if idx==NBITS-1; otherwise increment idx and go to CLEAR.
REQ-023 SHALL, in DONE: pulse done=1 for 1 cycle with busy=0, then go to IDLE.
REQ-024 SHALL hold busy=1 in CLEAR, RUN, SETTLE and COMPARE.
REQ-025 SHALL take exactly NBITS*(win_len+4) cycles from the start edge to the done pulse.
REQ-026 SHALL ignore start asserted in any state other than IDLE.
REQ-027 SHALL ignore changes on win_len during an evaluation.
REQ-028 SHALL compare counts of 255 or equal counts without error (no wrap handling); equal counts yield a 0 bit.
REQ-029 SHALL hold sel at the current idx in every non-IDLE state, and at 0 in IDLE.

Reset
REQ-030 SHALL, while rst_n=1, force the FSM to IDLE and drive ro_en=0, cnt_clr=0, sel=0, busy=0, done=0, response=0, tie_mask=0 and idx=0.
REQ-031 SHALL apply reset immediately, including mid-RUN: ro_en drops without waiting for a clock edge.
REQ-032 SHALL resume from IDLE after reset release, with no done pulse for the aborted evaluation.

Configuration
REQ-033 SHALL support the macro PUF_TIE_FLAG_EN.
REQ-034 SHALL, with PUF_TIE_FLAG_EN defined, write tie_mask[idx] = (cnt_a == cnt_b) in COMPARE.
REQ-035 SHALL, without PUF_TIE_FLAG_EN, keep the tie_mask port present and drive it constant 0.

Verification
REQ-036 Bench SHALL cover: NBITS=8, win_len=10, cnt_a=50 and cnt_b=40 for every index -> done exactly 112 cycles after start, response=8'hFF.
REQ-037 Bench SHALL cover: cnt_a>cnt_b only when sel is odd -> response=8'hAA; sel sequence 0..7 is observed in CLEAR.
REQ-038 Bench SHALL cover: win_len=0 -> ro_en high for exactly 1 cycle per bit; done 40 cycles after start.
REQ-039 Bench SHALL cover: cnt_a=cnt_b=255 -> response=0; tie_mask=8'hFF with PUF_TIE_FLAG_EN, 8'h00 without it.
REQ-040 Bench SHALL cover: rst_n=1 in the 3rd RUN cycle of bit 2 -> ro_en=0 asynchronously, all outputs 0, no done pulse; a new start runs a full evaluation.
REQ-041 Bench SHALL cover: start re-asserted while busy and win_len changed mid-evaluation -> total latency and response are unaffected.
